// File: rtl/slave_out.sv
// rtl/slave_out.sv - slave-side serial read-data transmitter
// Fetches words from local memory and shifts them out LSB first after a valid/ready handshake.
module slave_out #(
  parameter int DATA_LEN  = 8,
  parameter int BURST_LEN = 12,
  parameter int ADDR_LEN  = 12
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [ADDR_LEN-1:0]  i_start_addr,
  input  logic [BURST_LEN-1:0] i_burst_num,
  input  logic                 i_master_ready,
  input  logic [DATA_LEN-1:0]  i_mem_rd_data,
  output logic                 o_mem_rd_en,
  output logic [ADDR_LEN-1:0]  o_mem_addr,
  output logic                 o_slave_valid,
  output logic                 o_tx_data,
  output logic                 o_tx_done,
  output logic                 o_rd_complete,
  output logic                 o_busy
);

  localparam int CW = $clog2(DATA_LEN + 1);
  localparam int RW = BURST_LEN + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_LEN);
  localparam logic [RW-1:0] REM_ONE  = RW'(1);
  localparam logic [RW-1:0] REM_TWO  = RW'(2);

  typedef enum logic [1:0] {IDLE, FETCH, VALID, SEND} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_LEN-1:0] r_addr, w_addr_nxt;
  logic [RW-1:0]       r_rem, w_rem_nxt;
  logic [DATA_LEN-1:0] r_shift, w_shift_nxt;
  logic [DATA_LEN-1:0] r_next, w_next_nxt;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;
  logic                r_pend;
  logic                r_rd_en, w_rd_en_nxt;
  logic                r_valid, w_valid_nxt;
  logic                r_tx, w_tx_nxt;
  logic                r_done, w_done_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_rdc, w_rdc_nxt;

  // r_rem counts words still to be sent, including the one in the shift register
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_rem_nxt   = r_rem;
    w_shift_nxt = r_shift;
    w_next_nxt  = r_pend ? i_mem_rd_data : r_next;
    w_cnt_nxt   = r_cnt;
    w_rd_en_nxt = 1'b0;
    w_valid_nxt = r_valid;
    w_tx_nxt    = r_tx;
    w_done_nxt  = r_done;
    w_busy_nxt  = r_busy;
    w_rdc_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_addr_nxt  = i_start_addr;
          w_rem_nxt   = {1'b0, i_burst_num} + REM_ONE;
          w_rd_en_nxt = 1'b1;
          w_done_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (r_pend) begin
          w_shift_nxt = i_mem_rd_data;
          w_valid_nxt = 1'b1;
          w_state_nxt = VALID;
        end
      end
      VALID: begin
        if (i_master_ready) begin
          w_valid_nxt = 1'b0;
          w_tx_nxt    = r_shift[0];
          w_shift_nxt = r_shift >> 1;
          w_cnt_nxt   = CW'(1);
          w_state_nxt = SEND;
          if (r_rem > REM_ONE) begin
            w_rd_en_nxt = 1'b1;
            w_addr_nxt  = r_addr + 1'b1;
          end
        end
      end
      SEND: begin
        if (r_cnt != LAST_BIT) begin
          w_tx_nxt    = r_shift[0];
          w_shift_nxt = r_shift >> 1;
          w_cnt_nxt   = r_cnt + CW'(1);
        end else if (r_rem > REM_ONE) begin
          // word boundary: prefetched word goes straight out with no bubble
          w_rem_nxt   = r_rem - REM_ONE;
          w_tx_nxt    = r_next[0];
          w_shift_nxt = r_next >> 1;
          w_cnt_nxt   = CW'(1);
          if (r_rem > REM_TWO) begin
            w_rd_en_nxt = 1'b1;
            w_addr_nxt  = r_addr + 1'b1;
          end
        end else begin
          w_tx_nxt    = 1'b0;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_rdc_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_rem_nxt   = '0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_shift <= '0;
      r_next  <= '0;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_rd_en <= 1'b0;
      r_valid <= 1'b0;
      r_tx    <= 1'b0;
      r_done  <= 1'b1;
      r_busy  <= 1'b0;
      r_rdc   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_rem   <= w_rem_nxt;
      r_shift <= w_shift_nxt;
      r_next  <= w_next_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= r_rd_en;
      r_rd_en <= w_rd_en_nxt;
      r_valid <= w_valid_nxt;
      r_tx    <= w_tx_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
      r_rdc   <= w_rdc_nxt;
    end
  end

  assign o_mem_rd_en   = r_rd_en;
  assign o_mem_addr    = r_addr;
  assign o_slave_valid = r_valid;
  assign o_tx_data     = r_tx;
  assign o_tx_done     = r_done;
  assign o_rd_complete = r_rdc;
  assign o_busy        = r_busy;

endmodule

// File: doc/slave_out.md
Name: slave_out

Overview:
- Slave-side read-data transmitter: the driving end of the serial slave-to-master read path.
- On an accepted read request, fetches DATA_LEN-bit words from slave local memory and raises slave_valid.
- After handshake with master_ready, shifts burst_num+1 words onto tx_data, LSB first, one bit per clock, back-to-back with no gap cycles.
- Sits between the slave's request decoder and local memory on one side, and the bus return path to the master receive port on the other.

Parameters:
- DATA_LEN, 8, bits per word; legal minimum 4.
- BURST_LEN, 12, width of burst_num.
- ADDR_LEN, 12, slave local memory address width.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  read request from the slave request decoder; sampled only in IDLE.
- start_addr  input  ADDR_LEN  first word address; captured when start is accepted.
- burst_num  input  BURST_LEN  number of words minus 1; captured when start is accepted.
- master_ready  input  1  master receive port ready; handshake qualifier.
- mem_rd_data  input  DATA_LEN  memory read data; valid exactly 1 cycle after mem_rd_en.
- mem_rd_en  output  1  memory read strobe, 1-cycle pulse per word.
- mem_addr  output  ADDR_LEN  memory read address.
- slave_valid  output  1  slave has a word loaded and is ready to transmit.
- tx_data  output  1  serial data to master.
- tx_done  output  1  level; 1 when the block is idle and no transfer is outstanding.
- rd_complete  output  1  one-cycle pulse after the last bit of the last word.
- busy  output  1  complement of tx_done.

Behaviour:
- Reset values: slave_valid=0, tx_data=0, tx_done=1, busy=0, rd_complete=0, mem_rd_en=0, mem_addr=0. Internal counters and buffers are 0; state is IDLE.
- Reset asserted mid-transfer aborts immediately; no rd_complete is issued.
- All outputs are registered.
- States: IDLE, FETCH, VALID, SEND.
- IDLE:
  - rd_complete=0.
  - On start=1, capture start_addr and burst_num (word count = burst_num+1).
  - Next cycle: mem_rd_en=1, mem_addr=start_addr, tx_done=0, busy=1. Go to FETCH.
  - start outside IDLE is ignored.
- FETCH:
  - One wait cycle for memory latency.
  - Next edge: load mem_rd_data into the shift register, set slave_valid=1, go to VALID.
- VALID:
  - Hold slave_valid=1 indefinitely until master_ready=1 is seen at a posedge (edge E0).
  - At E0: slave_valid<=0, tx_data<=word[0], bit index<=1, go to SEND.
- SEND:
  - At each edge, tx_data<=word[bit index] and the index increments.
  - Bit k of word w (0-based) is stable on tx_data over the cycle ending at edge E0+1+w*DATA_LEN+k.
  - Prefetch: while words remain, issue mem_rd_en for address+1 during the current word. The fetched word is held in a next-word buffer.
  - After the last bit of a non-final word is driven, the next edge drives next-word bit 0 with no bubble.
  - Address increments modulo 2^ADDR_LEN; wrap from all-ones to 0 is legal.
  - After the last bit of the final word is driven, the next edge returns to IDLE: tx_data<=0, tx_done<=1, busy<=0, rd_complete<=1 for one cycle.
- Total SEND-side length: (burst_num+1)*DATA_LEN bit cycles after E0.
- master_ready is ignored outside VALID; deassertion during SEND does not pause the stream.
- burst_num=0 gives a single word with no prefetch read.
- burst_num at maximum (all ones) transfers 2^BURST_LEN words; the word counter is BURST_LEN+1 bits wide.
- start asserted in the same cycle rd_complete pulses is accepted (block is in IDLE).

Test Plan:
- DATA_LEN=8, mem[0x010]=0xA5, start_addr=0x010, burst_num=0, master_ready=1 → mem_rd_en once at 0x010; slave_valid high 1 cycle; tx_data over E1..E8 = 1,0,1,0,0,1,0,1; rd_complete pulse after E8; tx_done back to 1.
- Burst: mem[0x020..0x022]=0x01,0x80,0xFF, burst_num=2 → 24 contiguous bits 10000000 00000001 11111111; exactly 3 mem_rd_en pulses; no gap cycle between words.
- Stalled handshake: master_ready=0 for 10 cycles after slave_valid rises → slave_valid held, tx_data=0, no extra memory reads; first data bit 1 cycle after master_ready=1.
- Address wrap: ADDR_LEN=12, start_addr=0xFFF, burst_num=1 → reads at 0xFFF then 0x000, both words transmitted in order.
- Reset mid-burst at bit 5 of word 1 → next cycle: all outputs at reset values, no rd_complete. A new start 2 cycles later completes normally.
- start pulsed during SEND → ignored; exactly burst_num+1 words sent; only one rd_complete.
